// File: rtl/adc_conv_ctrl.sv
// ---------------------------------------------------------------------------
// adc_conv_ctrl -- flash ADC conversion sequencer
//
// Sequences a flash comparator array through settle / latch / encode passes
// and presents the resulting binary code to a consumer with a valid/ready
// handshake. The captured thermometer code is encoded by popcount, which
// tolerates the residual bubbles of a bubble-corrected code.
//
// Build option:
//   ADC_AVG4_EN  when defined, each start runs four passes and code_out is
//                the truncated mean of the four popcounts. When undefined,
//                one pass per start and no accumulator is built.
//
// Parameters:
//   N       width of the thermometer code (bit 0 = lowest threshold)
//   W       output code width, 2^W-1 >= N
//   SETTLE  comparator settle cycles before each latch, 1..255
//
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous active-high reset
//   start       conversion request, sampled only while idle
//   busy        high whenever the sequencer is not idle
//   cmp_latch   latch strobe to the flash array
//   therm_in    thermometer code from the flash array
//   code_out    converted code
//   code_valid  code_out / overrange are valid
//   code_ready  consumer accepts the code
//   overrange   at least one pass of the result saturated (popcount == N)
//
// cmp_latch and code_valid are registered from the current state, so each
// trails its state by one cycle. The HOLD exit is therefore qualified by
// code_valid, so the consumer always sees at least one valid cycle.
// ---------------------------------------------------------------------------
module adc_conv_ctrl #(
  parameter int N      = 255,
  parameter int W      = 8,
  parameter int SETTLE = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  output logic         busy,
  output logic         cmp_latch,
  input  logic [N-1:0] therm_in,
  output logic [W-1:0] code_out,
  output logic         code_valid,
  input  logic         code_ready,
  output logic         overrange
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_LATCH,
    ST_ENCODE,
    ST_HOLD
  } state_t;

  state_t       state;
  logic [7:0]   settle_cnt;
  logic [N-1:0] therm_p0;
  logic [W-1:0] pcount_p0;

  function automatic logic [W-1:0] popcount(input logic [N-1:0] v);
    logic [W-1:0] s;
    s = '0;
    for (int i = 0; i < N; i++) s = s + W'(v[i]);
    return s;
  endfunction

`ifdef ADC_AVG4_EN
  logic [1:0]   pass_cnt;
  logic [W+1:0] acc;
  logic [W+1:0] acc_sum;

  // Mean of four passes: divide by four, truncating.
  function automatic logic [W-1:0] avg4(input logic [W+1:0] s);
    return s[W+1:2];
  endfunction

  always_comb begin
    acc_sum = acc + {2'b00, pcount_p0};
  end
`endif

  // Encode stage: popcount of the thermometer code captured at the latch.
  always_comb begin
    pcount_p0 = popcount(therm_p0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      settle_cnt <= '0;
      busy       <= 1'b0;
      cmp_latch  <= 1'b0;
      code_valid <= 1'b0;
      therm_p0   <= '0;
      code_out   <= '0;
      overrange  <= 1'b0;
`ifdef ADC_AVG4_EN
      pass_cnt   <= '0;
      acc        <= '0;
`endif
    end else begin
      cmp_latch  <= (state == ST_LATCH);
      code_valid <= (state == ST_HOLD) && !(code_valid && code_ready);

      case (state)
        ST_IDLE: begin
          if (start) begin
            state      <= ST_SETTLE;
            busy       <= 1'b1;
            settle_cnt <= 8'(SETTLE - 1);
            overrange  <= 1'b0;
`ifdef ADC_AVG4_EN
            pass_cnt   <= '0;
            acc        <= '0;
`endif
          end
        end

        ST_SETTLE: begin
          if (settle_cnt == 8'd0) state <= ST_LATCH;
          else                    settle_cnt <= settle_cnt - 8'd1;
        end

        // Latch stage: sample the comparator outputs.
        ST_LATCH: begin
          therm_p0 <= therm_in;
          state    <= ST_ENCODE;
        end

        ST_ENCODE: begin
          if (pcount_p0 == W'(N)) overrange <= 1'b1;
`ifdef ADC_AVG4_EN
          acc      <= acc_sum;
          pass_cnt <= pass_cnt + 2'd1;
          if (pass_cnt == 2'd3) begin
            code_out <= avg4(acc_sum);
            state    <= ST_HOLD;
          end else begin
            settle_cnt <= 8'(SETTLE - 1);
            state      <= ST_SETTLE;
          end
`else
          code_out <= pcount_p0;
          state    <= ST_HOLD;
`endif
        end

        // Hold stage: wait for the consumer; start is not looked at here.
        ST_HOLD: begin
          if (code_valid && code_ready) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end

        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adc_conv_ctrl.sv
module tb_adc_conv_ctrl;
  localparam int N      = 255;
  localparam int W      = 8;
  localparam int SETTLE = 4;
`ifdef ADC_AVG4_EN
  localparam int PASSES = 4;
  localparam int LAT    = 4 * (SETTLE + 2) + 1;
`else
  localparam int PASSES = 1;
  localparam int LAT    = SETTLE + 3;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         busy;
  logic         cmp_latch;
  logic [N-1:0] therm_in;
  logic [W-1:0] code_out;
  logic         code_valid;
  logic         code_ready;
  logic         overrange;

  adc_conv_ctrl #(.N(N), .W(W), .SETTLE(SETTLE)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .cmp_latch(cmp_latch),
    .therm_in(therm_in), .code_out(code_out), .code_valid(code_valid),
    .code_ready(code_ready), .overrange(overrange)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] code;
    logic         ovr;
    int           sedge;
  } exp_t;

  exp_t q[$];
  int tests = 0;
  int fails = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, req, $time);
    end
  endtask

  function automatic logic [N-1:0] therm_of(input int pc);
    logic [N-1:0] t;
    t = '0;
    for (int i = 0; i < N; i++) if (i < pc) t[i] = 1'b1;
    return t;
  endfunction

  // Reference: the code is the count of asserted comparators, averaged
  // (truncating) over the passes of one request; overrange if any pass is full.
  function automatic exp_t model(input int pcs[4]);
    exp_t e;
    int sum;
    sum   = 0;
    e.ovr = 1'b0;
    for (int p = 0; p < PASSES; p++) begin
      sum += pcs[p];
      if (pcs[p] == N) e.ovr = 1'b1;
    end
    e.code  = W'(sum / PASSES);
    e.sedge = 0;
    return e;
  endfunction

  // which: 0 = cmp_latch, 1 = code_valid, 2 = busy
  task automatic wait_sig(input int which, input logic lvl, input string nm);
    logic v;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      v = (which == 0) ? cmp_latch : (which == 1) ? code_valid : busy;
      if (v === lvl) return;
    end
    check({nm, "_timeout"}, 0, 1);
  endtask

  // Monitor: pops the scoreboard on every rising code_valid.
  initial begin : monitor
    logic pv;
    logic stable;
    exp_t e;
    pv = 1'b0;
    stable = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pv = 1'b0;
      end else begin
        if (code_valid && !pv) begin
          if (q.size() == 0) begin
            check("unexpected_valid", 1, 0);
          end else begin
            e = q.pop_front();
            stable = 1'b1;
            check("code_out", code_out, e.code);
            check("overrange", overrange, e.ovr);
            check("latency", cyc - e.sedge, LAT);
          end
        end else if (code_valid && pv) begin
          if (code_out !== e.code || overrange !== e.ovr) stable = 1'b0;
        end else if (!code_valid && pv) begin
          check("hold_stable", stable, 1);
        end
        pv = code_valid;
      end
    end
  end

  task automatic run_conv(input int pcs[4], input int hold_n);
    exp_t e;
    logic [N-1:0] th[4];
    for (int p = 0; p < 4; p++) th[p] = therm_of(pcs[p]);
    e = model(pcs);
    @(negedge clk);
    therm_in = th[0];
    start    = 1'b1;
    e.sedge  = cyc + 1;
    q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    for (int p = 1; p < PASSES; p++) begin
      wait_sig(0, 1'b1, "latch_hi");
      therm_in = th[p];
      wait_sig(0, 1'b0, "latch_lo");
    end
    wait_sig(1, 1'b1, "valid");
    repeat (hold_n) @(negedge clk);
    code_ready = 1'b1;
    @(negedge clk);
    code_ready = 1'b0;
    check("exit_valid", code_valid, 0);
    check("exit_busy", busy, 0);
  endtask

  initial begin : stim
    int pcs[4];
    exp_t e;
    int s;
    logic seen;

    rst = 1'b1;
    start = 1'b0;
    code_ready = 1'b0;
    therm_in = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_latch", cmp_latch, 0);
    check("rst_valid", code_valid, 0);
    check("rst_code", code_out, 0);
    check("rst_ovr", overrange, 0);
    rst = 1'b0;
    @(negedge clk);

    // Directed patterns
    pcs = '{8, 8, 8, 8};       run_conv(pcs, 2);
    pcs = '{N, N, N, N};       run_conv(pcs, 10);
    pcs = '{0, 0, 0, 0};       run_conv(pcs, 0);
    pcs = '{10, 11, 11, 13};   run_conv(pcs, 1);
    pcs = '{N, 0, 0, 0};       run_conv(pcs, 3);
    pcs = '{N - 1, N, 1, 0};   run_conv(pcs, 0);

    // start held high: HOLD ignores it, the next IDLE edge honours it
    pcs = '{200, 200, 200, 200};
    e = model(pcs);
    @(negedge clk);
    therm_in = therm_of(200);
    start    = 1'b1;
    e.sedge  = cyc + 1;
    q.push_back(e);
    wait_sig(1, 1'b1, "valid_c1");
    repeat (3) @(negedge clk);
    check("hold_ignores_start", busy, 1);
    code_ready = 1'b1;
    @(negedge clk);
    code_ready = 1'b0;
    check("cont_idle", busy, 0);
    e.sedge = cyc + 1;
    q.push_back(e);
    @(negedge clk);
    check("cont_restart", busy, 1);
    start = 1'b0;
    wait_sig(1, 1'b1, "valid_c2");
    code_ready = 1'b1;
    @(negedge clk);
    code_ready = 1'b0;

    // Reset while the array is being latched
    @(negedge clk);
    therm_in = therm_of(100);
    start    = 1'b1;
    s        = cyc + 1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 50 && cyc < s + SETTLE; i++) @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_latch", cmp_latch, 0);
    check("mid_rst_valid", code_valid, 0);
    check("mid_rst_code", code_out, 0);
    check("mid_rst_ovr", overrange, 0);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      seen = seen | code_valid | busy;
    end
    check("no_valid_after_rst", seen, 0);

    // Randomized conversions
    for (int t = 0; t < 20; t++) begin
      for (int p = 0; p < 4; p++) begin
        case ($urandom_range(0, 5))
          0:       pcs[p] = 0;
          1:       pcs[p] = N;
          default: pcs[p] = int'($urandom_range(0, N));
        endcase
      end
      run_conv(pcs, int'($urandom_range(0, 4)));
    end

    repeat (3) @(negedge clk);
    check("queue_empty", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/adc_conv_ctrl.md
ADC_CONV_CTRL -- requirements
Module: adc_conv_ctrl

Interface
REQ-001 SHALL have parameter N, default 255: width of the bubble-corrected thermometer code.
REQ-002 SHALL have parameter W, default 8: output code width, with 2^W-1 >= N.
REQ-003 SHALL have parameter SETTLE, default 4, range 1..255: comparator settle cycles before each latch.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  conversion request; sampled only in IDLE.
REQ-007 busy  output  1  high in every state except IDLE.
REQ-008 cmp_latch  output  1  comparator latch strobe to the flash array.
REQ-009 therm_in  input  N  bubble-corrected thermometer code; bit 0 is the lowest threshold.
REQ-010 code_out  output  W  converted code.
REQ-011 code_valid  output  1  code_out and overrange are valid.
REQ-012 code_ready  input  1  consumer accepts the code.
REQ-013 overrange  output  1  at least one conversion in the result saturated.

Function
REQ-014 SHALL implement FSM states IDLE, SETTLE, LATCH, ENCODE, HOLD.
REQ-015 IDLE: start=1 at edge k -> SETTLE at k; start=0 -> stay in IDLE.
REQ-016 SETTLE SHALL last exactly SETTLE cycles, counted by a settle counter loaded on entry; cmp_latch=0 throughout; then -> LATCH.
REQ-017 LATCH SHALL last exactly 1 cycle with cmp_latch=1; therm_in SHALL be registered on the edge that leaves LATCH; then -> ENCODE.
REQ-018 ENCODE SHALL last 1 cycle and register popcount(captured therm) as an unsigned value 0..N.
REQ-019 ENCODE: on the last conversion of the result -> HOLD; otherwise -> SETTLE.
REQ-020 In the single-conversion build, code_valid SHALL rise exactly SETTLE+3 edges after the start-sampling edge (7 with defaults).
REQ-021 HOLD: code_valid=1, and code_out/overrange SHALL stay stable until code_ready=1; code_ready=1 -> IDLE on that edge.
REQ-022 code_valid SHALL be 0 in all states other than HOLD.
REQ-023 start SHALL be ignored in all states other than IDLE, including HOLD with code_ready=1; no request is queued.
REQ-024 overrange SHALL be set when any conversion of the result has popcount N, and cleared on leaving IDLE.
REQ-025 All-zero therm_in SHALL give code_out=0 and overrange=0.
REQ-026 code_out SHALL hold its last value after HOLD exits until the next ENCODE update.

Reset
REQ-027 rst=1 SHALL immediately force state=IDLE, busy=0, cmp_latch=0, code_valid=0, code_out=0, overrange=0, and clear all counters and the accumulator, regardless of the current state.
REQ-028 A reset asserted mid-conversion SHALL discard the partial result; after release, no code_valid occurs until a new start.

Configuration
REQ-029 Macro ADC_AVG4_EN SHALL select the averaging build.
REQ-030 With ADC_AVG4_EN defined: each start SHALL run 4 back-to-back SETTLE/LATCH/ENCODE passes.
REQ-031 With ADC_AVG4_EN defined: each popcount SHALL be added into a (W+2)-bit accumulator cleared on leaving IDLE.
REQ-032 With ADC_AVG4_EN defined: code_out SHALL be accumulator>>2 (truncating).
REQ-033 With ADC_AVG4_EN defined: code_valid SHALL rise 4*(SETTLE+2)+1 edges after start (25 with defaults).
REQ-034 With ADC_AVG4_EN defined: overrange SHALL be the OR of all 4 passes.
REQ-035 Without ADC_AVG4_EN: exactly one pass per start, code_out = popcount, and no accumulator SHALL be synthesized.

Verification
REQ-036 Defaults, no macro; therm_in=0x...00FF (8 ones), start pulse -> cmp_latch high for 1 cycle 5 cycles after start; code_valid at +7; code_out=8, overrange=0.
REQ-037 therm_in all-ones -> code_out=255, overrange=1; hold code_ready=0 for 10 cycles -> outputs stable and code_valid held.
REQ-038 start=1 continuously, code_ready=1 in HOLD -> HOLD->IDLE, then a new conversion starts on the next IDLE edge; start is not honoured inside HOLD.
REQ-039 rst pulse during LATCH -> outputs zero immediately; no code_valid for 20 cycles without start.
REQ-040 ADC_AVG4_EN; therm popcounts 10, 11, 11, 13 across the 4 passes -> code_valid at +25, code_out=11 (45>>2).
REQ-041 ADC_AVG4_EN; one pass all-ones and three passes 0 -> overrange=1, code_out=63 (255>>2).
